// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter giving NUM_CH requesters byte-serial access to an 8-bit RAM/IO bus.
// Handles 1/2/4-byte little-endian transfers, pipelined reads and rdy stalls.
module mem_arbiter_rr #(
    parameter int NUM_CH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NUM_CH-1:0]     ch_req,
    input  logic [NUM_CH-1:0]     ch_we,
    input  logic [2*NUM_CH-1:0]   ch_size,
    input  logic [32*NUM_CH-1:0]  ch_addr,
    input  logic [32*NUM_CH-1:0]  ch_wdata,
    output logic [NUM_CH-1:0]     ch_grant,
    output logic [NUM_CH-1:0]     ch_done,
    output logic [31:0]           rdata,
    output logic                  busy,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [31:0]           ram_a,
    output logic                  ram_rw
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   ch_reg, ch_next;
    logic [CW-1:0]   last_reg, last_next;
    logic [31:0]     base_reg, base_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic [31:0]     rdata_reg, rdata_next;
    logic [2:0]      n_reg, n_next;
    logic [2:0]      c_reg, c_next;
    logic            pend_reg, pend_next;

    logic [31:0]     addr_arr  [NUM_CH];
    logic [31:0]     wdata_arr [NUM_CH];
    logic [1:0]      size_arr  [NUM_CH];

    logic [CW-1:0]   sel, sel_lo, sel_hi;
    logic            any_lo, any_hi;
    logic [2:0]      sel_n;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign addr_arr[gi]  = ch_addr[32*gi +: 32];
            assign wdata_arr[gi] = ch_wdata[32*gi +: 32];
            assign size_arr[gi]  = ch_size[2*gi +: 2];
            assign ch_grant[gi]  = (state_reg != IDLE) && (ch_reg == CW'(gi));
            assign ch_done[gi]   = (state_reg == DONE) && rdy && (ch_reg == CW'(gi));
        end
    endgenerate

    // Round robin: lowest requester above the pointer, else lowest requester overall.
    always_comb begin
        sel_lo = '0;
        sel_hi = '0;
        any_lo = 1'b0;
        any_hi = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_req[i]) begin
                sel_lo = CW'(i);
                any_lo = 1'b1;
                if (CW'(i) > last_reg) begin
                    sel_hi = CW'(i);
                    any_hi = 1'b1;
                end
            end
        end
        sel = any_hi ? sel_hi : sel_lo;
        case (size_arr[sel])
            2'b00:   sel_n = 3'd1;
            2'b01:   sel_n = 3'd2;
            default: sel_n = 3'd4;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        last_next  = last_reg;
        base_next  = base_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        n_next     = n_reg;
        c_next     = c_reg;
        pend_next  = pend_reg;
        ram_a      = 32'd0;
        ram_rw     = 1'b0;
        ram_dout   = 8'd0;

        if (!rdy) begin
            // An in-flight read address is abandoned; base+c gets reissued on resume.
            pend_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_lo) begin
                        ch_next    = sel;
                        last_next  = sel;
                        base_next  = addr_arr[sel];
                        wdata_next = wdata_arr[sel];
                        n_next     = sel_n;
                        c_next     = 3'd0;
                        pend_next  = 1'b0;
                        rdata_next = 32'd0;
                        state_next = ch_we[sel] ? WRITE : READ;
                    end
                end
                WRITE: begin
                    ram_rw   = 1'b1;
                    ram_a    = base_reg + {29'd0, c_reg};
                    ram_dout = wdata_reg[{c_reg[1:0], 3'b000} +: 8];
                    c_next   = c_reg + 3'd1;
                    if (c_reg + 3'd1 == n_reg)
                        state_next = DONE;
                end
                READ: begin
                    if (pend_reg)
                        rdata_next[{c_reg[1:0], 3'b000} +: 8] = ram_din;
                    c_next = c_reg + {2'b00, pend_reg};
                    if (c_reg + {2'b00, pend_reg} < n_reg) begin
                        ram_a     = base_reg + {29'd0, c_reg} + {31'd0, pend_reg};
                        pend_next = 1'b1;
                    end else begin
                        pend_next = 1'b0;
                    end
                    if (c_reg + {2'b00, pend_reg} == n_reg)
                        state_next = DONE;
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ch_reg    <= '0;
            last_reg  <= CW'(NUM_CH - 1);
            base_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            n_reg     <= 3'd0;
            c_reg     <= 3'd0;
            pend_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            last_reg  <= last_next;
            base_reg  <= base_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            n_reg     <= n_next;
            c_reg     <= c_next;
            pend_reg  <= pend_next;
        end
    end

    assign rdata = rdata_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr (NUM_CH = 2) with a one-cycle-latency byte RAM model.
module tb_mem_arbiter_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [1:0]  ch_req = '0;
    logic [1:0]  ch_we = '0;
    logic [3:0]  ch_size = '0;
    logic [63:0] ch_addr = '0;
    logic [63:0] ch_wdata = '0;
    logic [1:0]  ch_grant;
    logic [1:0]  ch_done;
    logic [31:0] rdata;
    logic        busy;
    logic [7:0]  ram_din = '0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_rw;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [logic [31:0]];

    mem_arbiter_rr #(.NUM_CH(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ch_req(ch_req), .ch_we(ch_we), .ch_size(ch_size),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_grant(ch_grant), .ch_done(ch_done), .rdata(rdata), .busy(busy),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_rw(ram_rw)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // RAM returns the byte for the address presented in the previous cycle.
    always @(posedge clk) begin
        ram_din <= mem_rd(ram_a);
        if (ram_rw)
            mem[ram_a] = ram_dout;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
        mem[32'h200] = 8'hA1; mem[32'h201] = 8'hB2; mem[32'h202] = 8'hC3; mem[32'h203] = 8'hD4;
        mem[32'h300] = 8'h5A; mem[32'h301] = 8'h6B;
        mem[32'h30000] = 8'h7F; mem[32'h30001] = 8'hEE;

        // Reset state
        tick;
        chk("rst_grant", 32'(ch_grant), 32'h0);
        chk("rst_done", 32'(ch_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_ram_rw", 32'(ram_rw), 32'h0);
        rst = 1'b0;
        tick;

        // 4-byte read ch0 from 0x100
        ch_req = 2'b01; ch_we = 2'b00; ch_size[1:0] = 2'b10; ch_addr[31:0] = 32'h100;
        chk("rd4_c0_busy", 32'(busy), 32'h0);
        tick; chk("rd4_c1_a", ram_a, 32'h100); chk("rd4_c1_grant", 32'(ch_grant), 32'h1);
        chk("rd4_c1_rw", 32'(ram_rw), 32'h0);
        tick; chk("rd4_c2_a", ram_a, 32'h101);
        tick; chk("rd4_c3_a", ram_a, 32'h102);
        tick; chk("rd4_c4_a", ram_a, 32'h103);
        tick; chk("rd4_c5_a", ram_a, 32'h0); chk("rd4_c5_done", 32'(ch_done), 32'h0);
        tick; chk("rd4_c6_done", 32'(ch_done), 32'h1); chk("rd4_rdata", rdata, 32'h44332211);
        ch_req = 2'b00;
        tick; chk("rd4_idle_busy", 32'(busy), 32'h0); chk("rd4_idle_done", 32'(ch_done), 32'h0);

        // 1-byte read from IO space, upper bytes must clear
        ch_req = 2'b01; ch_size[1:0] = 2'b00; ch_addr[31:0] = 32'h30000;
        tick; chk("rd1_c1_a", ram_a, 32'h30000);
        tick; chk("rd1_c2_done", 32'(ch_done), 32'h0); chk("rd1_c2_a", ram_a, 32'h0);
        tick; chk("rd1_c3_done", 32'(ch_done), 32'h1); chk("rd1_rdata", rdata, 32'h0000007F);
        ch_req = 2'b00;
        tick;

        // 2-byte write on ch1
        ch_req = 2'b10; ch_we = 2'b10; ch_size[3:2] = 2'b01;
        ch_addr[63:32] = 32'h2001; ch_wdata[63:32] = 32'hA5B6C7D8;
        tick; chk("wr2_c1_a", ram_a, 32'h2001); chk("wr2_c1_dout", 32'(ram_dout), 32'hD8);
        chk("wr2_c1_rw", 32'(ram_rw), 32'h1); chk("wr2_c1_grant", 32'(ch_grant), 32'h2);
        tick; chk("wr2_c2_a", ram_a, 32'h2002); chk("wr2_c2_dout", 32'(ram_dout), 32'hC7);
        chk("wr2_c2_rw", 32'(ram_rw), 32'h1);
        tick; chk("wr2_c3_rw", 32'(ram_rw), 32'h0); chk("wr2_c3_done", 32'(ch_done), 32'h2);
        ch_req = 2'b00; ch_we = 2'b00;
        tick;
        chk("wr2_mem_2001", 32'(mem_rd(32'h2001)), 32'hD8);
        chk("wr2_mem_2002", 32'(mem_rd(32'h2002)), 32'hC7);
        chk("wr2_mem_2003_untouched", 32'(mem.exists(32'h2003)), 32'h0);

        // Fairness: both channels issue 1-byte reads continuously
        ch_size = 4'b0000; ch_addr[31:0] = 32'h300; ch_addr[63:32] = 32'h301;
        ch_req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            logic [1:0] g;
            g = (t % 2 == 0) ? 2'b01 : 2'b10;
            tick; chk($sformatf("rr%0d_grant", t), 32'(ch_grant), 32'(g));
            tick; chk($sformatf("rr%0d_c2_done", t), 32'(ch_done), 32'h0);
            tick; chk($sformatf("rr%0d_done", t), 32'(ch_done), 32'(g));
            chk($sformatf("rr%0d_rdata", t), rdata, (t % 2 == 0) ? 32'h5A : 32'h6B);
            if (t == 3) ch_req = 2'b00;
            tick; chk($sformatf("rr%0d_idle_busy", t), 32'(busy), 32'h0);
        end

        // 4-byte read with rdy low in cycles 3 and 4
        ch_req = 2'b01; ch_size[1:0] = 2'b10; ch_addr[31:0] = 32'h200;
        tick; chk("st_c1_a", ram_a, 32'h200);
        tick; chk("st_c2_a", ram_a, 32'h201);
        tick; rdy = 1'b0; #1 chk("st_c3_a", ram_a, 32'h0); chk("st_c3_rw", 32'(ram_rw), 32'h0);
        tick; #1 chk("st_c4_a", ram_a, 32'h0);
        tick; rdy = 1'b1; #1 chk("st_c5_a", ram_a, 32'h201);
        tick; chk("st_c6_a", ram_a, 32'h202);
        tick; chk("st_c7_a", ram_a, 32'h203);
        tick; chk("st_c8_done", 32'(ch_done), 32'h0); chk("st_c8_a", ram_a, 32'h0);
        tick; chk("st_c9_done", 32'(ch_done), 32'h1); chk("st_rdata", rdata, 32'hD4C3B2A1);
        ch_req = 2'b00;
        tick;

        // Reset during cycle 2 of a 4-byte write, then both channels request
        ch_req = 2'b01; ch_we = 2'b01; ch_size[1:0] = 2'b10;
        ch_addr[31:0] = 32'h400; ch_wdata[31:0] = 32'h11223344;
        tick; chk("rw_c1_a", ram_a, 32'h400); chk("rw_c1_rw", 32'(ram_rw), 32'h1);
        tick; chk("rw_c2_a", ram_a, 32'h401);
        #2 rst = 1'b1; ch_req = 2'b00;
        #1 chk("rw_rst_rw", 32'(ram_rw), 32'h0); chk("rw_rst_a", ram_a, 32'h0);
        chk("rw_rst_dout", 32'(ram_dout), 32'h0); chk("rw_rst_grant", 32'(ch_grant), 32'h0);
        chk("rw_rst_busy", 32'(busy), 32'h0);
        tick;
        rst = 1'b0;
        ch_we = 2'b00; ch_size = 4'b0000; ch_addr[31:0] = 32'h30000; ch_addr[63:32] = 32'h301;
        ch_req = 2'b11;
        tick; chk("ar_c1_grant", 32'(ch_grant), 32'h1); chk("ar_c1_a", ram_a, 32'h30000);
        chk("rw_mem_400", 32'(mem_rd(32'h400)), 32'h44);
        chk("rw_mem_401_untouched", 32'(mem.exists(32'h401)), 32'h0);
        tick;
        tick; chk("ar_c3_done", 32'(ch_done), 32'h1); chk("ar_rdata", rdata, 32'h7F);
        ch_req = 2'b00;
        tick; chk("ar_idle_busy", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
